// File: rtl/reservation_stations.sv
// Reservation-station array: accepts dispatched entries, wakes operands from two CDBs,
// and issues the oldest ready entry into a registered valid/ready issue slot.
module reservation_stations #(
  parameter int unsigned RS_SIZE = 8,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CTRL_W  = 16,
  localparam int unsigned ID_W   = $clog2(RS_SIZE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              alloc_valid,
  input  logic [ID_W-1:0]   alloc_id,
  input  logic [CTRL_W-1:0] alloc_ctrl,
  input  logic [TAG_W-1:0]  alloc_tag,
  input  logic [DATA_W-1:0] alloc_v1,
  input  logic [DATA_W-1:0] alloc_v2,
  input  logic [TAG_W-1:0]  alloc_t1,
  input  logic [TAG_W-1:0]  alloc_t2,
  input  logic [DATA_W-1:0] alloc_imm,
  input  logic [TAG_W-1:0]  cdb1_tag,
  input  logic [DATA_W-1:0] cdb1_value,
  input  logic [TAG_W-1:0]  cdb2_tag,
  input  logic [DATA_W-1:0] cdb2_value,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [CTRL_W-1:0] issue_ctrl,
  output logic [TAG_W-1:0]  issue_tag,
  output logic [DATA_W-1:0] issue_v1,
  output logic [DATA_W-1:0] issue_v2,
  output logic [DATA_W-1:0] issue_imm,
  output logic [ID_W-1:0]   free_id,
  output logic              rs_full
);

  localparam logic [ID_W-1:0] AGE_MAX = ID_W'(RS_SIZE - 1);

  logic [RS_SIZE-1:0] busy;
  logic [CTRL_W-1:0]  ctrl [RS_SIZE];
  logic [TAG_W-1:0]   tag  [RS_SIZE];
  logic [DATA_W-1:0]  v1   [RS_SIZE];
  logic [DATA_W-1:0]  v2   [RS_SIZE];
  logic [TAG_W-1:0]   t1   [RS_SIZE];
  logic [TAG_W-1:0]   t2   [RS_SIZE];
  logic [DATA_W-1:0]  imm  [RS_SIZE];
  logic [ID_W-1:0]    age  [RS_SIZE];

  logic [RS_SIZE-1:0] ready;
  logic               any_ready;
  logic [ID_W-1:0]    sel_id;
  logic [ID_W-1:0]    sel_age;
  logic               load;
  logic               alloc_en;
  logic [DATA_W-1:0]  a_v1, a_v2;
  logic [TAG_W-1:0]   a_t1, a_t2;
  logic               free_found;

  // Oldest-ready select from registered state; strict compare keeps lowest index on ties.
  always_comb begin
    ready     = '0;
    any_ready = 1'b0;
    sel_id    = '0;
    sel_age   = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      ready[i] = busy[i] && (t1[i] == '0) && (t2[i] == '0);
      if (ready[i] && (!any_ready || (age[i] > sel_age))) begin
        any_ready = 1'b1;
        sel_id    = ID_W'(i);
        sel_age   = age[i];
      end
    end
  end

  always_comb begin
    free_id    = '0;
    free_found = 1'b0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (!busy[i] && !free_found) begin
        free_found = 1'b1;
        free_id    = ID_W'(i);
      end
    end
  end

  assign rs_full  = &busy;
  assign load     = any_ready && !flush && (!issue_valid || issue_ready);
  assign alloc_en = alloc_valid && !flush && !busy[alloc_id];

  // Capture operands broadcast in the same cycle as allocation.
  always_comb begin
    a_v1 = alloc_v1;
    a_t1 = alloc_t1;
    a_v2 = alloc_v2;
    a_t2 = alloc_t2;
    if (alloc_t1 != '0) begin
      if (alloc_t1 == cdb1_tag) begin
        a_v1 = cdb1_value;
        a_t1 = '0;
      end else if (alloc_t1 == cdb2_tag) begin
        a_v1 = cdb2_value;
        a_t1 = '0;
      end
    end
    if (alloc_t2 != '0) begin
      if (alloc_t2 == cdb1_tag) begin
        a_v2 = cdb1_value;
        a_t2 = '0;
      end else if (alloc_t2 == cdb2_tag) begin
        a_v2 = cdb2_value;
        a_t2 = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        ctrl[i] <= '0;
        tag[i]  <= '0;
        v1[i]   <= '0;
        v2[i]   <= '0;
        t1[i]   <= '0;
        t2[i]   <= '0;
        imm[i]  <= '0;
        age[i]  <= '0;
      end
    end else if (flush) begin
      busy <= '0;
      for (int unsigned i = 0; i < RS_SIZE; i++) age[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < RS_SIZE; i++) begin
        if (alloc_en && (alloc_id == ID_W'(i))) begin
          busy[i] <= 1'b1;
          ctrl[i] <= alloc_ctrl;
          tag[i]  <= alloc_tag;
          v1[i]   <= a_v1;
          t1[i]   <= a_t1;
          v2[i]   <= a_v2;
          t2[i]   <= a_t2;
          imm[i]  <= alloc_imm;
          age[i]  <= '0;
        end else if (busy[i]) begin
          if (t1[i] != '0) begin
            if (t1[i] == cdb1_tag) begin
              v1[i] <= cdb1_value;
              t1[i] <= '0;
            end else if (t1[i] == cdb2_tag) begin
              v1[i] <= cdb2_value;
              t1[i] <= '0;
            end
          end
          if (t2[i] != '0) begin
            if (t2[i] == cdb1_tag) begin
              v2[i] <= cdb1_value;
              t2[i] <= '0;
            end else if (t2[i] == cdb2_tag) begin
              v2[i] <= cdb2_value;
              t2[i] <= '0;
            end
          end
          if (load && (sel_id == ID_W'(i))) busy[i] <= 1'b0;
          if (alloc_en && (age[i] != AGE_MAX)) age[i] <= age[i] + ID_W'(1);
        end
      end
    end
  end

  // Issue slot: load on free or draining slot, hold under backpressure.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_valid <= 1'b0;
      issue_ctrl  <= '0;
      issue_tag   <= '0;
      issue_v1    <= '0;
      issue_v2    <= '0;
      issue_imm   <= '0;
    end else if (flush) begin
      issue_valid <= 1'b0;
    end else if (load) begin
      issue_valid <= 1'b1;
      issue_ctrl  <= ctrl[sel_id];
      issue_tag   <= tag[sel_id];
      issue_v1    <= v1[sel_id];
      issue_v2    <= v2[sel_id];
      issue_imm   <= imm[sel_id];
    end else if (issue_valid && issue_ready) begin
      issue_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reservation_stations.sv
// Bench for reservation_stations: vector table for allocation/bypass plus directed
// sequences for wakeup, age order, backpressure, flush and async reset.
module tb_reservation_stations;

  localparam int unsigned RS_SIZE = 8;
  localparam int unsigned TAG_W   = 6;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CTRL_W  = 16;
  localparam int unsigned ID_W    = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              alloc_valid;
  logic [ID_W-1:0]   alloc_id;
  logic [CTRL_W-1:0] alloc_ctrl;
  logic [TAG_W-1:0]  alloc_tag;
  logic [DATA_W-1:0] alloc_v1, alloc_v2, alloc_imm;
  logic [TAG_W-1:0]  alloc_t1, alloc_t2;
  logic [TAG_W-1:0]  cdb1_tag, cdb2_tag;
  logic [DATA_W-1:0] cdb1_value, cdb2_value;
  logic              issue_valid;
  logic              issue_ready;
  logic [CTRL_W-1:0] issue_ctrl;
  logic [TAG_W-1:0]  issue_tag;
  logic [DATA_W-1:0] issue_v1, issue_v2, issue_imm;
  logic [ID_W-1:0]   free_id;
  logic              rs_full;

  reservation_stations #(
    .RS_SIZE(RS_SIZE), .TAG_W(TAG_W), .DATA_W(DATA_W), .CTRL_W(CTRL_W)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_id(alloc_id), .alloc_ctrl(alloc_ctrl),
    .alloc_tag(alloc_tag), .alloc_v1(alloc_v1), .alloc_v2(alloc_v2),
    .alloc_t1(alloc_t1), .alloc_t2(alloc_t2), .alloc_imm(alloc_imm),
    .cdb1_tag(cdb1_tag), .cdb1_value(cdb1_value),
    .cdb2_tag(cdb2_tag), .cdb2_value(cdb2_value),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_ctrl(issue_ctrl), .issue_tag(issue_tag), .issue_v1(issue_v1),
    .issue_v2(issue_v2), .issue_imm(issue_imm),
    .free_id(free_id), .rs_full(rs_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] v1;
    logic [DATA_W-1:0] v2;
    logic [DATA_W-1:0] imm;
    logic [CTRL_W-1:0] ctrl;
  } exp_t;

  typedef struct {
    logic [TAG_W-1:0]  tag, t1, t2, c1t, c2t;
    logic [DATA_W-1:0] v1, v2, imm, c1v, c2v;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] ev1, ev2;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] a,
                      input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] im,
                      input logic [CTRL_W-1:0] c);
    exp_t e;
    e.tag = t; e.v1 = a; e.v2 = b; e.imm = im; e.ctrl = c;
    sb.push_back(e);
  endtask

  // One clock: score any handshake at the falling edge, return just after the rising edge.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    if (reset && issue_valid && issue_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected_issue: got tag %0h expected no issue", issue_tag);
      end else begin
        e = sb.pop_front();
        check("sb_tag",  64'(issue_tag),  64'(e.tag));
        check("sb_v1",   64'(issue_v1),   64'(e.v1));
        check("sb_v2",   64'(issue_v2),   64'(e.v2));
        check("sb_imm",  64'(issue_imm),  64'(e.imm));
        check("sb_ctrl", 64'(issue_ctrl), 64'(e.ctrl));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 1'b0;
    flush       = 1'b0;
    cdb1_tag    = '0;
    cdb2_tag    = '0;
    cdb1_value  = '0;
    cdb2_value  = '0;
  endtask

  task automatic drive_alloc(input logic [ID_W-1:0] id, input logic [CTRL_W-1:0] c,
                             input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] a,
                             input logic [TAG_W-1:0] at, input logic [DATA_W-1:0] b,
                             input logic [TAG_W-1:0] bt, input logic [DATA_W-1:0] im);
    alloc_valid = 1'b1;
    alloc_id    = id;
    alloc_ctrl  = c;
    alloc_tag   = t;
    alloc_v1    = a;
    alloc_t1    = at;
    alloc_v2    = b;
    alloc_t2    = bt;
    alloc_imm   = im;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // tag, t1, t2, cdb1 tag, cdb2 tag, v1, v2, imm, cdb1 val, cdb2 val, ctrl, exp v1, exp v2
    vecs[0] = '{6'd10, 6'd0, 6'd0, 6'd0, 6'd0, 32'h1, 32'h2, 32'h100, 32'h0, 32'h0, 16'h0a0a, 32'h1, 32'h2};
    vecs[1] = '{6'd11, 6'd5, 6'd0, 6'd5, 6'd0, 32'hdead, 32'h3, 32'h101, 32'h55, 32'h0, 16'h0b0b, 32'h55, 32'h3};
    vecs[2] = '{6'd12, 6'd0, 6'd6, 6'd6, 6'd0, 32'h4, 32'hbeef, 32'h102, 32'h66, 32'h0, 16'h0c0c, 32'h4, 32'h66};
    vecs[3] = '{6'd13, 6'd7, 6'd8, 6'd7, 6'd8, 32'hf1, 32'hf2, 32'h103, 32'h77, 32'h88, 16'h0d0d, 32'h77, 32'h88};
    vecs[4] = '{6'd14, 6'd0, 6'd0, 6'd9, 6'd0, 32'h5, 32'h6, 32'h104, 32'h99, 32'h0, 16'h0e0e, 32'h5, 32'h6};
    vecs[5] = '{6'd15, 6'd0, 6'd3, 6'd3, 6'd3, 32'h7, 32'hf3, 32'h105, 32'h33, 32'h33, 16'h0f0f, 32'h7, 32'h33};

    reset = 1'b0;
    issue_ready = 1'b1;
    alloc_id = '0; alloc_ctrl = '0; alloc_tag = '0;
    alloc_v1 = '0; alloc_v2 = '0; alloc_t1 = '0; alloc_t2 = '0; alloc_imm = '0;
    idle();
    #12;
    check("rst_issue_valid", 64'(issue_valid), 64'd0);
    check("rst_rs_full",     64'(rs_full),     64'd0);
    check("rst_free_id",     64'(free_id),     64'd0);
    check("rst_issue_tag",   64'(issue_tag),   64'd0);
    reset = 1'b1;
    cyc();

    // Single issue with two-edge latency
    drive_alloc(3'd0, 16'h0003, 6'd3, 32'd5, 6'd0, 32'd7, 6'd0, 32'h11);
    push(6'd3, 32'd5, 32'd7, 32'h11, 16'h0003);
    cyc();
    idle();
    check("t1_not_yet_valid", 64'(issue_valid), 64'd0);
    check("t1_free_id_busy",  64'(free_id),     64'd1);
    cyc();
    check("t1_issue_valid", 64'(issue_valid), 64'd1);
    check("t1_issue_tag",   64'(issue_tag),   64'd3);
    check("t1_issue_v1",    64'(issue_v1),    64'd5);
    check("t1_issue_v2",    64'(issue_v2),    64'd7);
    check("t1_free_id_back", 64'(free_id),    64'd0);
    cyc();
    check("t1_drained", 64'(issue_valid), 64'd0);

    // Vector table: allocation with and without same-cycle CDB capture
    for (int i = 0; i < 6; i++) begin
      drive_alloc(free_id, vecs[i].ctrl, vecs[i].tag, vecs[i].v1, vecs[i].t1,
                  vecs[i].v2, vecs[i].t2, vecs[i].imm);
      cdb1_tag = vecs[i].c1t; cdb1_value = vecs[i].c1v;
      cdb2_tag = vecs[i].c2t; cdb2_value = vecs[i].c2v;
      push(vecs[i].tag, vecs[i].ev1, vecs[i].ev2, vecs[i].imm, vecs[i].ctrl);
      cyc();
    end
    idle();
    repeat (4) cyc();
    check("tbl_drained", 64'(sb.size()), 64'd0);

    // Wakeup via cdb2 one cycle after allocation
    drive_alloc(free_id, 16'h0044, 6'd4, 32'd0, 6'd2, 32'd9, 6'd0, 32'h1);
    push(6'd4, 32'haa, 32'd9, 32'h1, 16'h0044);
    cyc();
    idle();
    cyc();
    check("wk_waiting", 64'(issue_valid), 64'd0);
    cdb2_tag = 6'd2; cdb2_value = 32'haa;
    cyc();
    idle();
    check("wk_not_same_cycle", 64'(issue_valid), 64'd0);
    cyc();
    check("wk_issue_valid", 64'(issue_valid), 64'd1);
    check("wk_issue_v1",    64'(issue_v1),    64'haa);
    cyc();

    // Age ordering: slots 2,0,1 all wait on tag 9
    drive_alloc(3'd2, 16'h1, 6'd1, 32'd0, 6'd9, 32'd1, 6'd0, 32'h0);
    push(6'd1, 32'h99, 32'd1, 32'h0, 16'h1);
    cyc();
    drive_alloc(3'd0, 16'h2, 6'd2, 32'd0, 6'd9, 32'd2, 6'd0, 32'h0);
    push(6'd2, 32'h99, 32'd2, 32'h0, 16'h2);
    cyc();
    drive_alloc(3'd1, 16'h3, 6'd3, 32'd0, 6'd9, 32'd3, 6'd0, 32'h0);
    push(6'd3, 32'h99, 32'd3, 32'h0, 16'h3);
    cyc();
    idle();
    cdb1_tag = 6'd9; cdb1_value = 32'h99;
    cyc();
    idle();
    cyc();
    check("age_first",  64'(issue_tag), 64'd1);
    cyc();
    check("age_second", 64'(issue_tag), 64'd2);
    cyc();
    check("age_third",  64'(issue_tag), 64'd3);
    cyc();
    check("age_drained", 64'(sb.size()), 64'd0);

    // Backpressure: two ready entries, execute stalls three cycles
    issue_ready = 1'b0;
    drive_alloc(free_id, 16'h20, 6'd20, 32'h20, 6'd0, 32'h21, 6'd0, 32'h22);
    push(6'd20, 32'h20, 32'h21, 32'h22, 16'h20);
    cyc();
    drive_alloc(free_id, 16'h21, 6'd21, 32'h30, 6'd0, 32'h31, 6'd0, 32'h32);
    push(6'd21, 32'h30, 32'h31, 32'h32, 16'h21);
    cyc();
    idle();
    for (int k = 0; k < 3; k++) begin
      check("bp_valid_held", 64'(issue_valid), 64'd1);
      check("bp_tag_held",   64'(issue_tag),   64'd20);
      check("bp_v1_held",    64'(issue_v1),    64'h20);
      check("bp_free_id",    64'(free_id),     64'd0);
      if (k < 2) cyc();
    end
    issue_ready = 1'b1;
    cyc();
    check("bp_second_issue", 64'(issue_tag), 64'd21);
    check("bp_second_valid", 64'(issue_valid), 64'd1);
    cyc();
    check("bp_drained_valid", 64'(issue_valid), 64'd0);
    check("bp_drained", 64'(sb.size()), 64'd0);

    // Full, then flush together with a dropped allocation
    for (int i = 0; i < 8; i++) begin
      drive_alloc(3'(i), 16'(i), 6'(40 + i), 32'(i), 6'(30 + i), 32'd0, 6'd0, 32'd0);
      cyc();
    end
    idle();
    check("full_rs_full", 64'(rs_full), 64'd1);
    check("full_free_id", 64'(free_id), 64'd0);
    drive_alloc(3'd3, 16'h60, 6'd60, 32'h60, 6'd0, 32'h61, 6'd0, 32'h62);
    flush = 1'b1;
    cyc();
    idle();
    check("fl_rs_full",     64'(rs_full),     64'd0);
    check("fl_free_id",     64'(free_id),     64'd0);
    check("fl_issue_valid", 64'(issue_valid), 64'd0);
    cyc();
    cyc();
    check("fl_alloc_dropped", 64'(issue_valid), 64'd0);
    cdb1_tag = 6'd30; cdb1_value = 32'h1;
    cyc();
    idle();
    cyc();
    check("fl_no_ghost_wake", 64'(issue_valid), 64'd0);

    // Async reset mid-stream with a held issue slot and a full array
    issue_ready = 1'b0;
    drive_alloc(free_id, 16'h50, 6'd50, 32'h50, 6'd0, 32'h51, 6'd0, 32'h52);
    push(6'd50, 32'h50, 32'h51, 32'h52, 16'h50);
    cyc();
    for (int k = 0; k < 8; k++) begin
      drive_alloc(free_id, 16'(k), 6'(40 + k), 32'd0, 6'd50, 32'd0, 6'd0, 32'd0);
      cyc();
    end
    idle();
    check("ar_pre_valid", 64'(issue_valid), 64'd1);
    check("ar_pre_full",  64'(rs_full),     64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("ar_issue_valid", 64'(issue_valid), 64'd0);
    check("ar_rs_full",     64'(rs_full),     64'd0);
    check("ar_issue_tag",   64'(issue_tag),   64'd0);
    check("ar_free_id",     64'(free_id),     64'd0);
    sb.delete();
    #3;
    reset = 1'b1;
    issue_ready = 1'b1;
    cyc();
    check("ar_after_release", 64'(issue_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
